// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg: shared constants and types for the stopwatch run controller.
// Contents: FSM state encoding, default lap counter width, default debounce
// length and the board clock frequency.
package stopwatch_pkg;

  localparam int unsigned CLK_HZ         = 50_000_000;
  localparam int unsigned LAP_W_DEF      = 4;
  // 20 ms of stable key level at CLK_HZ
  localparam int unsigned DEB_CYCLES_DEF = 1_000_000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_LAP   = 2'd2,
    ST_PAUSE = 2'd3
  } state_t;

  // Counter advances on ticks only while running (RUN or LAP).
  function automatic logic is_counting(input state_t s);
    return (s == ST_RUN) || (s == ST_LAP);
  endfunction

endpackage

// File: rtl/key_debounce.sv
// key_debounce: synchronises one raw active-low push-button and debounces it.
// Ports:
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_key_n        : raw key, active-low, asynchronous to i_clk
//   o_level        : debounced key level (1 = released)
//   o_press        : one-cycle pulse on the debounced 1->0 transition
module key_debounce #(
  parameter int unsigned DEB_CYCLES = 1_000_000
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_key_n,
  output logic o_level,
  output logic o_press
);

  localparam int unsigned     CNT_W    = $clog2(DEB_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic [CNT_W-1:0] r_cnt;
  logic             r_level;
  logic             r_press;

  // Two-flop synchroniser; resets to the released level.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= i_key_n;
      r_sync2 <= r_sync1;
    end
  end

  // Accept a new level after DEB_CYCLES consecutive differing samples;
  // any sample matching the current level restarts the count.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt   <= '0;
      r_level <= 1'b1;
      r_press <= 1'b0;
    end else begin
      r_press <= 1'b0;
      if (r_sync2 == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        r_cnt   <= '0;
        r_level <= r_sync2;
        r_press <= ~r_sync2;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign o_level = r_level;
  assign o_press = r_press;

endmodule

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: run controller for the centisecond stopwatch counter chain.
// Debounces start/stop and lap/reset keys and sequences IDLE/RUN/LAP/PAUSE.
// Optional feature macro: STOPWATCH_LAP_EN (lap view and lap counter).
// Ports:
//   CLOCK_50, RST_N          : clock, asynchronous active-low reset
//   key_start_n, key_lap_n   : raw active-low keys
//   tick_10ms                : 10 ms tick pulse
//   cnt_en                   : counter enable (combinational from tick_10ms)
//   cnt_clr                  : one-cycle counter clear (registered)
//   disp_hold                : display freeze while in LAP
//   running                  : high in RUN or LAP
//   lap_cnt                  : laps taken since last clear
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = DEB_CYCLES_DEF,
  parameter int unsigned LAP_W      = LAP_W_DEF
) (
  input  logic             CLOCK_50,
  input  logic             RST_N,
  input  logic             key_start_n,
  input  logic             key_lap_n,
  input  logic             tick_10ms,
  output logic             cnt_en,
  output logic             cnt_clr,
  output logic             disp_hold,
  output logic             running,
  output logic [LAP_W-1:0] lap_cnt
);

  logic   w_start_press;
  logic   w_lap_press;
  logic   w_start_level;
  logic   w_lap_level;
  logic   w_unused_levels;

  state_t r_state;
  logic   r_armed;
  logic   r_clr;
  logic   r_running;
`ifdef STOPWATCH_LAP_EN
  logic             r_disp_hold;
  logic [LAP_W-1:0] r_lap_cnt;
`endif

  key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_start (
    .i_clk   (CLOCK_50),
    .i_rst_n (RST_N),
    .i_key_n (key_start_n),
    .o_level (w_start_level),
    .o_press (w_start_press)
  );

  key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_lap (
    .i_clk   (CLOCK_50),
    .i_rst_n (RST_N),
    .i_key_n (key_lap_n),
    .o_level (w_lap_level),
    .o_press (w_lap_press)
  );

  // Debounced levels are not needed here; only press events drive the FSM.
  assign w_unused_levels = w_start_level ^ w_lap_level;

  // Run FSM with registered outputs. Start wins over a same-cycle lap event.
  // r_armed makes cnt_clr pulse on the first edge after reset release,
  // initialising the counter which has no reset of its own.
  always_ff @(posedge CLOCK_50 or negedge RST_N) begin
    if (!RST_N) begin
      r_state     <= ST_IDLE;
      r_armed     <= 1'b0;
      r_clr       <= 1'b0;
      r_running   <= 1'b0;
`ifdef STOPWATCH_LAP_EN
      r_disp_hold <= 1'b0;
      r_lap_cnt   <= '0;
`endif
    end else begin
      r_armed <= 1'b1;
      r_clr   <= ~r_armed;
      case (r_state)
        ST_IDLE: begin
          if (w_start_press) begin
            r_state   <= ST_RUN;
            r_running <= 1'b1;
          end
        end
        ST_RUN: begin
          if (w_start_press) begin
            r_state   <= ST_PAUSE;
            r_running <= 1'b0;
          end
`ifdef STOPWATCH_LAP_EN
          else if (w_lap_press) begin
            r_state     <= ST_LAP;
            r_disp_hold <= 1'b1;
            r_lap_cnt   <= r_lap_cnt + LAP_W'(1);
          end
`endif
        end
`ifdef STOPWATCH_LAP_EN
        ST_LAP: begin
          if (w_start_press) begin
            r_state     <= ST_PAUSE;
            r_running   <= 1'b0;
            r_disp_hold <= 1'b0;
          end else if (w_lap_press) begin
            r_state     <= ST_RUN;
            r_disp_hold <= 1'b0;
          end
        end
`endif
        ST_PAUSE: begin
          if (w_start_press) begin
            r_state   <= ST_RUN;
            r_running <= 1'b1;
          end else if (w_lap_press) begin
            r_state <= ST_IDLE;
            r_clr   <= 1'b1;
`ifdef STOPWATCH_LAP_EN
            r_lap_cnt <= '0;
`endif
          end
        end
        default: begin
          r_state   <= ST_IDLE;
          r_running <= 1'b0;
        end
      endcase
    end
  end

  // Zero-latency enable from the current (pre-transition) state.
  assign cnt_en  = tick_10ms & is_counting(r_state);
  assign cnt_clr = r_clr;
  assign running = r_running;
`ifdef STOPWATCH_LAP_EN
  assign disp_hold = r_disp_hold;
  assign lap_cnt   = r_lap_cnt;
`else
  assign disp_hold = 1'b0;
  assign lap_cnt   = '0;
`endif

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb_stopwatch_ctrl: self-checking bench for stopwatch_ctrl (DEB_CYCLES=4,
// tick every 10 cycles). Every cycle is compared against a behavioural model;
// a vector table and hand sequences add end-of-step checks.
module tb_stopwatch_ctrl;

  localparam int DEB    = 4;
  localparam int LW     = 4;
  localparam int TICK_P = 10;
`ifdef STOPWATCH_LAP_EN
  localparam bit LAP_EN = 1'b1;
`else
  localparam bit LAP_EN = 1'b0;
`endif

  logic          CLOCK_50    = 1'b0;
  logic          RST_N       = 1'b0;
  logic          key_start_n = 1'b1;
  logic          key_lap_n   = 1'b1;
  logic          tick_10ms   = 1'b0;
  logic          cnt_en;
  logic          cnt_clr;
  logic          disp_hold;
  logic          running;
  logic [LW-1:0] lap_cnt;

  stopwatch_ctrl #(.DEB_CYCLES(DEB), .LAP_W(LW)) dut (
    .CLOCK_50    (CLOCK_50),
    .RST_N       (RST_N),
    .key_start_n (key_start_n),
    .key_lap_n   (key_lap_n),
    .tick_10ms   (tick_10ms),
    .cnt_en      (cnt_en),
    .cnt_clr     (cnt_clr),
    .disp_hold   (disp_hold),
    .running     (running),
    .lap_cnt     (lap_cnt)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  int en_seen;
  int clr_seen;

  // ---------------- behavioural model ----------------
  typedef enum {M_IDLE, M_RUN, M_LAP, M_PAUSE} mstate_e;
  mstate_e        m_state;
  int             m_laps;
  bit             m_clr;
  int             m_edges;     // clock edges since reset release
  bit             m_ps, m_pl;  // press events visible this cycle
  bit             m_syn [2][2];
  bit             m_lvl [2];
  logic [DEB-1:0] m_win [2];   // last DEB synchronised samples

  function automatic void m_reset();
    m_state = M_IDLE;
    m_laps  = 0;
    m_clr   = 1'b0;
    m_edges = 0;
    m_ps    = 1'b0;
    m_pl    = 1'b0;
    for (int c = 0; c < 2; c++) begin
      m_syn[c][0] = 1'b1;
      m_syn[c][1] = 1'b1;
      m_lvl[c]    = 1'b1;
      m_win[c]    = '1;
    end
  endfunction

  // Level flips once the last DEB samples all disagree with it.
  function automatic bit m_deb(input int ch, input bit raw);
    bit s;
    s = m_syn[ch][1];
    m_syn[ch][1] = m_syn[ch][0];
    m_syn[ch][0] = raw;
    m_win[ch] = {m_win[ch][DEB-2:0], s};
    if (m_win[ch] == {DEB{~m_lvl[ch]}}) begin
      m_lvl[ch] = ~m_lvl[ch];
      m_win[ch] = {DEB{m_lvl[ch]}};
      return (m_lvl[ch] == 1'b0);
    end
    return 1'b0;
  endfunction

  function automatic void m_edge();
    bit ns, nl;
    m_clr = (m_edges == 0);
    case (m_state)
      M_IDLE:  if (m_ps) m_state = M_RUN;
      M_RUN: begin
        if (m_ps) m_state = M_PAUSE;
        else if (m_pl && LAP_EN) begin
          m_state = M_LAP;
          m_laps  = (m_laps + 1) % (1 << LW);
        end
      end
      M_LAP: begin
        if (m_ps) m_state = M_PAUSE;
        else if (m_pl) m_state = M_RUN;
      end
      M_PAUSE: begin
        if (m_ps) m_state = M_RUN;
        else if (m_pl) begin
          m_state = M_IDLE;
          m_clr   = 1'b1;
          m_laps  = 0;
        end
      end
      default: m_state = M_IDLE;
    endcase
    m_edges++;
    ns = m_deb(0, key_start_n);
    nl = m_deb(1, key_lap_n);
    m_ps = ns;
    m_pl = nl;
  endfunction

  // ---------------- checking ----------------
  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic check_outputs();
    bit counting;
    counting = (m_state == M_RUN) || (m_state == M_LAP);
    chk("cnt_en",    int'(cnt_en),    int'(tick_10ms && counting));
    chk("cnt_clr",   int'(cnt_clr),   int'(m_clr));
    chk("disp_hold", int'(disp_hold), int'(m_state == M_LAP));
    chk("running",   int'(running),   int'(counting));
    chk("lap_cnt",   int'(lap_cnt),   m_laps);
    if (cnt_en)  en_seen++;
    if (cnt_clr) clr_seen++;
  endtask

  // One clock cycle: entered 1 time unit after a rising edge.
  task automatic cycle();
    tick_10ms = (cyc % TICK_P == TICK_P - 1);
    #4;
    check_outputs();
    @(posedge CLOCK_50);
    if (RST_N) m_edge();
    cyc++;
    #1;
  endtask

  task automatic press(input bit s_n, input bit l_n);
    key_start_n = s_n;
    key_lap_n   = l_n;
    repeat (10) cycle();
    key_start_n = 1'b1;
    key_lap_n   = 1'b1;
    repeat (8) cycle();
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit s_n;
    bit l_n;
    int n;
    bit e_run;
    bit e_hold;
    int e_lap;
  } vec_t;
  vec_t vq[$];

  task automatic add(input bit s, input bit l, input int n,
                     input bit r, input bit h, input int lp);
    vec_t v;
    v.s_n = s; v.l_n = l; v.n = n; v.e_run = r; v.e_hold = h; v.e_lap = lp;
    vq.push_back(v);
  endtask

  // A press is 10 low cycles then 8 released; both steps share expectations.
  task automatic add_press(input bit s, input bit l, input bit r, input bit h, input int lp);
    add(s, l, 10, r, h, lp);
    add(1'b1, 1'b1, 8, r, h, lp);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: bench did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int lp;
    m_reset();

    // Start-up: outputs quiet during reset, one clear pulse after release.
    #1;
    repeat (3) cycle();
    RST_N    = 1'b1;
    clr_seen = 0;
    en_seen  = 0;
    repeat (50) cycle();
    chk("boot_clr_pulses", clr_seen, 1);
    chk("idle_en_pulses",  en_seen,  0);

    add(1'b1, 1'b1, 20, 1'b0, 1'b0, 0);
    add_press(1'b0, 1'b1, 1'b1, 1'b0, 0);                            // IDLE->RUN
    add(1'b1, 1'b1, 30, 1'b1, 1'b0, 0);
    add_press(1'b1, 1'b0, 1'b1, LAP_EN, LAP_EN ? 1 : 0);             // RUN->LAP
    add_press(1'b1, 1'b0, 1'b1, 1'b0, LAP_EN ? 1 : 0);               // LAP->RUN
    add_press(1'b0, 1'b1, 1'b0, 1'b0, LAP_EN ? 1 : 0);               // ->PAUSE
    add_press(1'b1, 1'b0, 1'b0, 1'b0, 0);                            // ->IDLE
    add_press(1'b0, 1'b1, 1'b1, 1'b0, 0);                            // ->RUN
    add_press(1'b1, 1'b0, 1'b1, LAP_EN, LAP_EN ? 1 : 0);
    add_press(1'b1, 1'b0, 1'b1, 1'b0, LAP_EN ? 1 : 0);
    add_press(1'b0, 1'b0, 1'b0, 1'b0, LAP_EN ? 1 : 0);               // both: start wins
    add_press(1'b1, 1'b0, 1'b0, 1'b0, 0);                            // ->IDLE
    add_press(1'b0, 1'b1, 1'b1, 1'b0, 0);                            // ->RUN
    for (int i = 0; i < 16; i++) begin
      lp = LAP_EN ? ((i + 1) % 16) : 0;
      add_press(1'b1, 1'b0, 1'b1, LAP_EN, lp);
      add_press(1'b1, 1'b0, 1'b1, 1'b0, lp);
    end

    foreach (vq[k]) begin
      key_start_n = vq[k].s_n;
      key_lap_n   = vq[k].l_n;
      repeat (vq[k].n) cycle();
      chk("vec_running",   int'(running),   int'(vq[k].e_run));
      chk("vec_disp_hold", int'(disp_hold), int'(vq[k].e_hold));
      chk("vec_lap_cnt",   int'(lap_cnt),   vq[k].e_lap);
    end

    // RUN: three ticks in 30 cycles give three enables.
    en_seen = 0;
    repeat (30) cycle();
    chk("run_en_pulses", en_seen, 3);

    // Bouncing start key: only the final stable press is an event (RUN->PAUSE).
    for (int g = 0; g < 2; g++) begin
      key_start_n = 1'b0; repeat (2) cycle();
      key_start_n = 1'b1; repeat (2) cycle();
    end
    key_start_n = 1'b0; repeat (10) cycle();
    key_start_n = 1'b1; repeat (8) cycle();
    chk("bounce_running", int'(running), 0);
    en_seen = 0;
    repeat (30) cycle();
    chk("pause_en_pulses", en_seen, 0);

    // PAUSE + lap: single clear pulse, back to IDLE.
    clr_seen = 0;
    press(1'b1, 1'b0);
    chk("pause_clr_pulses", clr_seen, 1);
    chk("pause_lap_cnt", int'(lap_cnt), 0);

    // Into LAP (RUN without the lap feature), start a debounce, then reset.
    press(1'b0, 1'b1);
    press(1'b1, 1'b0);
    chk("pre_rst_hold", int'(disp_hold), int'(LAP_EN));
    key_start_n = 1'b0;
    repeat (3) cycle();
    RST_N       = 1'b0;
    key_start_n = 1'b1;
    #1;
    m_reset();
    chk("rst_running",   int'(running),   0);
    chk("rst_disp_hold", int'(disp_hold), 0);
    chk("rst_lap_cnt",   int'(lap_cnt),   0);
    chk("rst_cnt_clr",   int'(cnt_clr),   0);
    chk("rst_cnt_en",    int'(cnt_en),    0);
    @(posedge CLOCK_50);
    cyc++;
    #1;
    RST_N    = 1'b1;
    clr_seen = 0;
    repeat (20) cycle();
    chk("post_rst_clr_pulses", clr_seen, 1);
    chk("post_rst_running", int'(running), 0);

    // Random key activity, including bounces and overlapping presses.
    for (int seg = 0; seg < 80; seg++) begin
      key_start_n = ($urandom_range(0, 2) == 0) ? 1'b0 : 1'b1;
      key_lap_n   = ($urandom_range(0, 2) == 0) ? 1'b0 : 1'b1;
      repeat ($urandom_range(1, 12)) cycle();
    end
    key_start_n = 1'b1;
    key_lap_n   = 1'b1;
    repeat (20) cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
